// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
package serial_pkg;

    localparam int DATA_W = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    // Parity bit over the data bits only; odd = 1 selects odd parity.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/tx_serial_frame_if.sv
// Producer-side valid/ready handshake for the serial frame transmitter.
interface tx_serial_frame_if;
    import serial_pkg::*;

    logic              valid;
    logic [DATA_W-1:0] data_in;
    logic              ready;

    modport master (output valid, output data_in, input ready);
    modport slave  (input valid, input data_in, output ready);

endinterface

// File: rtl/tx_serial_frame.sv
// Serial frame transmitter: start bit, 7 data bits LSB first, parity bit,
// STOP_BITS idle-level bits. A one-word holding buffer lets the producer
// queue the next word while the current frame is on the wire.
module tx_serial_frame
    import serial_pkg::*;
#(
    parameter logic START_SIG  = 1'b0,
    parameter logic PARITY_ODD = 1'b0,
    parameter int   STOP_BITS  = 2
) (
    input  logic              clk,
    input  logic              rstN,
    tx_serial_frame_if.slave  prod,
    output logic              s_out,
    output logic              busy,
    output logic              sent
);

    localparam logic       IDLE_LVL  = ~START_SIG;
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    tx_state_t         state;
    logic [2:0]        bit_idx;
    logic [3:0]        stop_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              par_reg;
    logic [DATA_W-1:0] hold_reg;
    logic              hold_full;
    logic              accept;
    logic              last_stop;
    logic              load_now;

    // A full buffer never accepts, even in the cycle it is being drained.
    assign prod.ready = !hold_full;
    assign accept     = prod.valid && !hold_full;
    assign last_stop  = (state == S_STOP) && (stop_cnt == STOP_LAST);
    assign load_now   = hold_full && ((state == S_IDLE) || last_stop);

    // Holding buffer: fill on accept, empty when the frame engine loads it.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hold_full <= 1'b0;
            hold_reg  <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_reg  <= prod.data_in;
        end else if (load_now) begin
            hold_full <= 1'b0;
        end
    end

    // Frame engine: walks start, data, parity and stop bits with registered outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= S_IDLE;
            s_out     <= IDLE_LVL;
            busy      <= 1'b0;
            sent      <= 1'b0;
            bit_idx   <= '0;
            stop_cnt  <= '0;
            shift_reg <= '0;
            par_reg   <= 1'b0;
        end else begin
            sent <= 1'b0;
            case (state)
                S_IDLE: begin
                    s_out <= IDLE_LVL;
                    busy  <= 1'b0;
                    if (load_now) begin
                        shift_reg <= hold_reg;
                        par_reg   <= parity_bit(hold_reg, PARITY_ODD);
                        s_out     <= START_SIG;
                        busy      <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    s_out     <= shift_reg[0];
                    shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
                    bit_idx   <= '0;
                    state     <= S_DATA;
                end
                S_DATA: begin
                    if (bit_idx == 3'd6) begin
                        s_out <= par_reg;
                        state <= S_PARITY;
                    end else begin
                        s_out     <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
                        bit_idx   <= bit_idx + 3'd1;
                    end
                end
                S_PARITY: begin
                    s_out    <= IDLE_LVL;
                    stop_cnt <= '0;
                    state    <= S_STOP;
                end
                S_STOP: begin
                    if (last_stop) begin
                        sent <= 1'b1;
                        if (load_now) begin
                            shift_reg <= hold_reg;
                            par_reg   <= parity_bit(hold_reg, PARITY_ODD);
                            s_out     <= START_SIG;
                            state     <= S_START;
                        end else begin
                            s_out <= IDLE_LVL;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else begin
                        stop_cnt <= stop_cnt + 4'd1;
                    end
                end
                default: begin
                    s_out <= IDLE_LVL;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_serial_frame.sv
// Bench for tx_serial_frame: two instances (start-low/even/2 stops and
// start-high/odd/3 stops) checked every cycle against a queue-based frame
// model, plus a decoder that recovers words from the observed line.
module tb_tx_serial_frame;
    import serial_pkg::*;

    localparam logic START0 = 1'b0;
    localparam logic ODD0   = 1'b0;
    localparam int   STOPS0 = 2;
    localparam logic START1 = 1'b1;
    localparam logic ODD1   = 1'b1;
    localparam int   STOPS1 = 3;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       valid_v [2];
    logic [6:0] data_v  [2];
    logic       s_out0, busy0, sent0;
    logic       s_out1, busy1, sent1;

    tx_serial_frame_if bus0 ();
    tx_serial_frame_if bus1 ();

    assign bus0.valid   = valid_v[0];
    assign bus0.data_in = data_v[0];
    assign bus1.valid   = valid_v[1];
    assign bus1.data_in = data_v[1];

    tx_serial_frame #(.START_SIG(START0), .PARITY_ODD(ODD0), .STOP_BITS(STOPS0)) dut0 (
        .clk(clk), .rstN(rstN), .prod(bus0), .s_out(s_out0), .busy(busy0), .sent(sent0)
    );

    tx_serial_frame #(.START_SIG(START1), .PARITY_ODD(ODD1), .STOP_BITS(STOPS1)) dut1 (
        .clk(clk), .rstN(rstN), .prod(bus1), .s_out(s_out1), .busy(busy1), .sent(sent1)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Reference model state: expected line bits as {last_of_frame, level}.
    bit   [1:0] exp_q  [2][$];
    logic [6:0] word_q [2][$];
    logic       log_q  [2][$];
    logic       hf_m [2];
    logic [6:0] hold_m [2];
    logic       line_m [2];
    logic       busy_m [2];
    logic       sent_m [2];
    logic       prev_last [2];
    int         busy_cnt [2];
    int         sent_cnt [2];
    int         n_assert = 0;
    int         n_fail = 0;

    function automatic logic start_sig(input int i);
        return (i == 0) ? START0 : START1;
    endfunction

    function automatic logic odd_sel(input int i);
        return (i == 0) ? ODD0 : ODD1;
    endfunction

    function automatic int stops(input int i);
        return (i == 0) ? STOPS0 : STOPS1;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset(input int i);
        exp_q[i].delete();
        word_q[i].delete();
        log_q[i].delete();
        hf_m[i]      = 1'b0;
        hold_m[i]    = '0;
        line_m[i]    = !start_sig(i);
        busy_m[i]    = 1'b0;
        sent_m[i]    = 1'b0;
        prev_last[i] = 1'b0;
    endtask

    // One clock edge of the model: load a whole frame when the line is free,
    // then pop the bit that goes on the wire for the next cycle.
    task automatic model_edge(input int i);
        logic     hf_old;
        logic     par;
        bit [1:0] e;
        hf_old    = hf_m[i];
        sent_m[i] = 1'b0;
        if (exp_q[i].size() == 0) begin
            sent_m[i] = prev_last[i];
            if (hf_old) begin
                par = (^hold_m[i]) ^ odd_sel(i);
                exp_q[i].push_back({1'b0, start_sig(i)});
                for (int b = 0; b < 7; b++) exp_q[i].push_back({1'b0, hold_m[i][b]});
                exp_q[i].push_back({1'b0, par});
                for (int s = 1; s < stops(i); s++) exp_q[i].push_back({1'b0, !start_sig(i)});
                exp_q[i].push_back({1'b1, !start_sig(i)});
                hf_m[i] = 1'b0;
            end
        end
        if (exp_q[i].size() != 0) begin
            e            = exp_q[i].pop_front();
            line_m[i]    = e[0];
            busy_m[i]    = 1'b1;
            prev_last[i] = e[1];
        end else begin
            line_m[i]    = !start_sig(i);
            busy_m[i]    = 1'b0;
            prev_last[i] = 1'b0;
        end
        if (valid_v[i] && !hf_old) begin
            hf_m[i]   = 1'b1;
            hold_m[i] = data_v[i];
            word_q[i].push_back(data_v[i]);
        end
    endtask

    task automatic check_output(input int i);
        logic so, bz, st, rd;
        so = (i == 0) ? s_out0 : s_out1;
        bz = (i == 0) ? busy0 : busy1;
        st = (i == 0) ? sent0 : sent1;
        rd = (i == 0) ? bus0.ready : bus1.ready;
        check_bit($sformatf("dut%0d s_out", i), so, line_m[i]);
        check_bit($sformatf("dut%0d busy", i), bz, busy_m[i]);
        check_bit($sformatf("dut%0d sent", i), st, sent_m[i]);
        check_bit($sformatf("dut%0d ready", i), rd, !hf_m[i]);
        log_q[i].push_back(so);
        if (bz === 1'b1) busy_cnt[i]++;
        if (st === 1'b1) sent_cnt[i]++;
    endtask

    task automatic apply_stimulus(input int i, input logic v, input logic [6:0] d);
        valid_v[i] = v;
        data_v[i]  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rstN) model_reset(i);
            else       model_edge(i);
        end
        @(negedge clk);
        check_output(0);
        check_output(1);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Offer one word and hold valid until the handshake completes.
    task automatic send_word(input int i, input logic [6:0] d);
        logic took;
        took = 1'b0;
        apply_stimulus(i, 1'b1, d);
        for (int k = 0; k < 40 && !took; k++) begin
            took = !hf_m[i];
            tick();
        end
        apply_stimulus(i, 1'b0, 7'h00);
        check_bit($sformatf("dut%0d accept within budget", i), took, 1'b1);
    endtask

    // Recover words from the logged line and compare with accepted words in order.
    task automatic decode_check(input int i);
        int         j;
        logic [6:0] w;
        logic [6:0] expw;
        j = 0;
        while (j + 9 <= log_q[i].size()) begin
            if (log_q[i][j] === start_sig(i)) begin
                for (int b = 0; b < 7; b++) w[b] = log_q[i][j + 1 + b];
                check_bit($sformatf("dut%0d rx parity", i), log_q[i][j + 8], (^w) ^ odd_sel(i));
                if (word_q[i].size() > 0) begin
                    expw = word_q[i].pop_front();
                    check_val($sformatf("dut%0d rx word", i), int'(w), int'(expw));
                end else begin
                    check_val($sformatf("dut%0d rx unexpected word", i), int'(w), -1);
                end
                j += 9 + stops(i);
            end else begin
                j++;
            end
        end
        check_val($sformatf("dut%0d words not received", i), word_q[i].size(), 0);
        log_q[i].delete();
    endtask

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with a randomized full-buffer phase.
    initial begin
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(i, 1'b0, 7'h00);
            model_reset(i);
            busy_cnt[i] = 0;
            sent_cnt[i] = 0;
        end
        $display("[TB] reset");
        ticks(3);
        rstN = 1'b1;
        ticks(2);

        $display("[TB] single word 0x55, even parity");
        busy_cnt[0] = 0;
        sent_cnt[0] = 0;
        send_word(0, 7'h55);
        ticks(16);
        check_val("dut0 busy cycles per frame", busy_cnt[0], 9 + STOPS0);
        check_val("dut0 sent pulses", sent_cnt[0], 1);
        decode_check(0);

        $display("[TB] odd parity, start high, 3 stop bits");
        busy_cnt[1] = 0;
        send_word(1, 7'h00);
        ticks(16);
        send_word(1, 7'h7F);
        ticks(16);
        send_word(1, 7'h2A);
        ticks(16);
        check_val("dut1 busy cycles for 3 frames", busy_cnt[1], 3 * (9 + STOPS1));
        decode_check(1);

        $display("[TB] back-to-back frames");
        sent_cnt[0] = 0;
        send_word(0, 7'h01);
        send_word(0, 7'h7E);
        ticks(30);
        check_val("dut0 back-to-back sent pulses", sent_cnt[0], 2);
        decode_check(0);

        $display("[TB] valid held high with random data");
        for (int c = 0; c < 80; c++) begin
            apply_stimulus(0, 1'b1, 7'($urandom));
            apply_stimulus(1, 1'b1, 7'($urandom));
            tick();
        end
        apply_stimulus(0, 1'b0, 7'h00);
        apply_stimulus(1, 1'b0, 7'h00);
        ticks(40);
        decode_check(0);
        decode_check(1);

        $display("[TB] reset during data bit 3");
        sent_cnt[0] = 0;
        send_word(0, 7'h4B);
        ticks(5);
        #2 rstN = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_output(0);
        check_output(1);
        tick();
        rstN = 1'b1;
        tick();
        check_val("dut0 sent pulses across reset", sent_cnt[0], 0);
        send_word(0, 7'h33);
        ticks(16);
        decode_check(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_serial_frame.md
Name: tx_serial_frame

Overview:
- Serial frame transmitter. It is the sending end of the single-wire, one-bit-per-clock link used by the team's serial receiver.
- Serialises 7-bit words into frames: start bit, 7 data bits LSB first, parity bit, then stop/guard bits.
- Has a one-word holding buffer with a valid/ready handshake, so a producer can queue the next word while the current frame is on the wire.

Parameters:
- START_SIG, 0, line level of the start bit; the idle/stop level is !START_SIG.
- PARITY_ODD, 0, 0 = even parity (parity bit = ^data), 1 = odd parity (parity bit = ~^data).
- STOP_BITS, 2, number of idle-level cycles after the parity bit; legal range 2..15. The minimum of 2 guarantees the receiver samples the idle level once before the next start bit.

Ports:
- clk  input  1  system clock; one line bit per cycle
- rstN  input  1  asynchronous active-low reset
- valid  input  1  producer offers data_in this cycle
- data_in  input  7  word to send
- ready  output  1  holding buffer empty; the word is accepted on an edge where valid && ready
- s_out  output  1  serial line, registered
- busy  output  1  a frame is in progress (state != S_IDLE), registered
- sent  output  1  one-cycle pulse in the cycle after the last stop bit of a frame, registered

Behaviour:
- Clocking and reset: single clock, asynchronous active-low reset (rstN), all state updates on posedge clk.
- Reset values: s_out = !START_SIG, busy = 0, sent = 0, hold_full = 0 (so ready = 1), state = S_IDLE, bit index = 0, shift and hold registers = 0. Reset asserted mid-frame aborts immediately; the line returns to idle level with no partial-frame completion.
- ready is combinational: ready = !hold_full. An accept sets hold_full and latches data_in into the hold register. A word is never accepted into a full buffer, even in the cycle the buffer is being drained.
- States:
  - S_IDLE: s_out = !START_SIG. If hold_full at the edge, load the shift register from hold, compute the parity bit, clear hold_full, drive s_out = START_SIG, go to S_START.
  - S_START: lasts 1 cycle, then drive data[0] and go to S_DATA with index = 0.
  - S_DATA: 7 cycles, driving data[index]. After index 6, drive the parity bit and go to S_PARITY.
  - S_PARITY: lasts 1 cycle, then drive !START_SIG and go to S_STOP with counter = 0.
  - S_STOP: lasts STOP_BITS cycles at idle level. On the edge ending the last stop cycle, pulse sent. If hold_full, reload and drive the start bit directly (back-to-back, no extra gap); otherwise go to S_IDLE.
- Latency: a word accepted at edge e while S_IDLE and the buffer is empty loads at edge e+1, so the start bit is on s_out for the cycle after e+1.
- Frame length on the wire: 9 + STOP_BITS cycles. Back-to-back frame period is the same.
- Simultaneous events:
  - A buffer drain and a new valid in the same cycle: no accept, because ready was 0.
  - The next valid is accepted one cycle after the drain.
- Width rules: parity is computed over the 7 data bits only. The stop counter is 4 bits wide.

Decomposition:
- Shared package (serial_pkg) holds:
  - state encodings S_IDLE, S_START, S_DATA, S_PARITY, S_STOP;
  - DATA_W = 7;
  - a parity function taking (data, odd) that is also usable by the receiver side.
- No sub-module. The holding buffer is two registers inline.
- The verification bench instantiates this block looped back into the existing serial receiver with a matching START_SIG.

Test Plan:
- Single word: reset, then valid=1 with data_in=7'h55 for one cycle, START_SIG=0, even parity → s_out bits after the load: 0, 1, 0, 1, 0, 1, 0, 1, parity 0, 1, 1. sent pulses once, busy is high for 11 cycles, and the loopback receiver reports data=7'h55, parity=0.
- Odd parity: PARITY_ODD=1, data_in=7'h00 → parity bit 1; with data_in=7'h7F → parity bit 0. Receiver data matches.
- Back-to-back: offer 7'h01, then 7'h7E while the first is in flight → second accepted during frame 1 with ready then 0. Frame 2's start bit immediately follows the last stop bit, giving an 11-cycle period. The receiver captures both words in order.
- Full buffer: hold valid=1 continuously with changing data → only words sampled when ready=1 are transmitted, none are duplicated or dropped relative to accepts, and ready is never 1 while hold_full.
- Reset mid-frame: assert rstN=0 during data bit 3 → s_out = !START_SIG asynchronously, busy=0, ready=1, no sent pulse. A new word afterwards is sent correctly.
- START_SIG=1, STOP_BITS=3: data_in=7'h2A → idle level 0, start 1, frame 12 cycles, receiver with START_SIG=1 captures 7'h2A.
